heater_sequencer: RTL and testbench
===================================

HEATER_SEQUENCER -- requirements
Module: heater_sequencer

Interface
REQ-001 SHALL have parameter N, default 16, meaning the number of heater channels.
REQ-002 SHALL have parameter MAX_ON, default 8, meaning the maximum number of simultaneously enabled channels (current limit).
REQ-003 SHALL have parameter STEP_CYCLES, default 1024, meaning the clock cycles between successive enable or disable steps.
REQ-004 SHALL have parameter CLEAR_CYCLES, default 4, meaning the err_clear pulse width in cycles.
REQ-005 SHALL provide one clock; reset is asynchronous and active-low: clk input 1 (the sole clock, same domain as the heater instances) and rst_n input 1 (asynchronous active-low reset).
REQ-006 SHALL provide start input 1: single-cycle request to begin the ramp-up.
REQ-007 SHALL provide stop input 1: single-cycle request to begin the ramp-down.
REQ-008 SHALL provide target_mask input N: channels to enable, sampled on start.
REQ-009 SHALL provide heater_enable output N: per-channel enable to the heaters.
REQ-010 SHALL provide heater_err_clear output N: per-channel error clear to the heaters.
REQ-011 SHALL provide heater_error input N: per-channel error from the heaters.
REQ-012 SHALL provide sticky_clr input 1: clears error_sticky and error_count.
REQ-013 SHALL provide error_sticky output N: latched error per channel.
REQ-014 SHALL provide error_count output 16: saturating total of error events.
REQ-015 SHALL provide busy output 1: high whenever the state is not IDLE.

Function
REQ-016 SHALL implement the states IDLE, RAMP_UP, RUN, CLEAR and RAMP_DOWN.
REQ-017 In IDLE, start SHALL latch target_mask into a target register, load the step timer with STEP_CYCLES and enter RAMP_UP; a start in any other state SHALL be ignored.
REQ-018 In RAMP_UP, each time the step timer expires, the block SHALL set the enable bit of the lowest-index targeted channel that is not yet enabled, then reload the timer.
REQ-019 RAMP_UP SHALL enter RUN on the cycle that all targeted channels are enabled or the enabled popcount equals MAX_ON, whichever occurs first; an all-zero target SHALL enter RUN after the first step timeout with no enables.
REQ-020 Enabled popcount SHALL never exceed MAX_ON.
REQ-021 Error event SHALL mean a rising edge of heater_error[i], detected against a one-cycle registered copy, while heater_enable[i] is 1; error edges on disabled channels SHALL be ignored.
REQ-022 Each error event SHALL set error_sticky[i] on the following cycle.
REQ-023 Each error event SHALL add to error_count the number of channels with an event that cycle, saturating at 16'hFFFF.
REQ-024 An error event in RAMP_UP or RUN SHALL enter CLEAR; the ramp timer SHALL freeze during CLEAR.
REQ-025 CLEAR SHALL assert heater_err_clear for exactly the channels with a pending error for CLEAR_CYCLES cycles, then return to the state it came from.
REQ-026 New error events during CLEAR SHALL be counted and stickied and SHALL be added to the channels being cleared, restarting the CLEAR count.
REQ-027 stop in RAMP_UP or RUN SHALL enter RAMP_DOWN; stop during CLEAR SHALL be held pending and taken once CLEAR completes; stop in IDLE SHALL be ignored.
REQ-028 RAMP_DOWN SHALL clear the highest-index enabled channel at each step timeout and enter IDLE on the cycle that heater_enable becomes zero.
REQ-029 Error edges SHALL be counted in RAMP_DOWN but SHALL NOT trigger CLEAR.
REQ-030 sticky_clr SHALL zero error_sticky and error_count on the next cycle; a simultaneous error event SHALL take priority, leaving the sticky bit set and error_count equal to that event's channel count.

Reset
REQ-031 rst_n low SHALL immediately force IDLE and set heater_enable, heater_err_clear, error_sticky, error_count, busy, the timers and the pending stop to 0, including mid-ramp and mid-CLEAR.

Configuration
REQ-032 With HEATER_SEQ_AUTOCLR_EN defined, CLEAR behaviour SHALL be as in REQ-024 to REQ-026.
REQ-033 Without HEATER_SEQ_AUTOCLR_EN, the CLEAR state SHALL be absent, heater_err_clear SHALL be constant 0, and errors SHALL be stickied and counted only.

Structure
REQ-034 The state enum and the default constants N, MAX_ON, STEP_CYCLES and CLEAR_CYCLES SHALL reside in the shared package heater_pkg.
REQ-035 One sub-module, heater_bit_pick, SHALL return the one-hot lowest or highest set bit of an N-bit vector together with a valid flag, and SHALL be used for both ramp directions.

Verification
REQ-036 Ramp-up: with N=16, MAX_ON=8, STEP_CYCLES=10, start with target_mask 16'hFFFF -> channels 0..7 enable at 10-cycle spacing, heater_enable reaches 16'h00FF, RUN is entered, and no further enables occur.
REQ-037 Error clear: in RUN, pulse heater_error[3] high -> error_sticky 16'h0008, error_count 1, and heater_err_clear[3] high for 4 cycles, then RUN is re-entered.
REQ-038 Simultaneous errors: rising edges on channels 1 and 5 in the same cycle -> error_count increases by 2; in a separate test, error_count preloaded near 16'hFFFF saturates at 16'hFFFF.
REQ-039 Stop during CLEAR: stop arrives 2 cycles into CLEAR -> the clear completes its 4 cycles, then RAMP_DOWN disables channel 7 first and channel 0 last, busy falls with heater_enable 0.
REQ-040 Reset mid-ramp: rst_n is asserted low with heater_enable 16'h0007 -> all outputs 0 in the same cycle, and a later start re-ramps from channel 0.
REQ-041 Macro off: with HEATER_SEQ_AUTOCLR_EN undefined, an error on channel 2 -> sticky bit set, count 1, heater_err_clear stays 0, and the state remains RUN.

Source files
------------

// File: rtl/heater_pkg.sv
// Shared state type, default constants and a saturating adder for the heater sequencer.
// HEATER_SEQ_AUTOCLR_EN adds the CLEAR state to the state type.
package heater_pkg;

  localparam int HEATER_N            = 16;
  localparam int HEATER_MAX_ON       = 8;
  localparam int HEATER_STEP_CYCLES  = 1024;
  localparam int HEATER_CLEAR_CYCLES = 4;

  typedef enum logic [2:0] {
    IDLE,
    RAMP_UP,
    RUN,
`ifdef HEATER_SEQ_AUTOCLR_EN
    CLEAR,
`endif
    RAMP_DOWN
  } heater_state_e;

  function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[16] ? 16'hFFFF : sum[15:0];
  endfunction

endpackage

// File: rtl/heater_bit_pick.sv
// One-hot pick of the lowest (high_i = 0) or highest (high_i = 1) set bit of a vector.
module heater_bit_pick
  import heater_pkg::*;
#(
  parameter int N = HEATER_N
) (
  input  logic [N-1:0] vec_i,
  input  logic         high_i,
  output logic [N-1:0] onehot_o,
  output logic         valid_o
);

  always_comb begin
    onehot_o = '0;
    valid_o  = 1'b0;
    if (high_i) begin
      for (int i = N - 1; i >= 0; i--) begin
        if (!valid_o && vec_i[i]) begin
          onehot_o[i] = 1'b1;
          valid_o     = 1'b1;
        end
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        if (!valid_o && vec_i[i]) begin
          onehot_o[i] = 1'b1;
          valid_o     = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/heater_sequencer.sv
// Current-limited heater enable ramp-up/ramp-down with error latching and counting.
// Define HEATER_SEQ_AUTOCLR_EN to add the automatic per-channel error-clear (CLEAR) state.
module heater_sequencer
  import heater_pkg::*;
#(
  parameter int N            = HEATER_N,
  parameter int MAX_ON       = HEATER_MAX_ON,
  parameter int STEP_CYCLES  = HEATER_STEP_CYCLES,
  parameter int CLEAR_CYCLES = HEATER_CLEAR_CYCLES
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         stop,
  input  logic [N-1:0] target_mask,
  output logic [N-1:0] heater_enable,
  output logic [N-1:0] heater_err_clear,
  input  logic [N-1:0] heater_error,
  input  logic         sticky_clr,
  output logic [N-1:0] error_sticky,
  output logic [15:0]  error_count,
  output logic         busy
);

  localparam int CW = $clog2(N + 1);
  localparam int TW = $clog2(STEP_CYCLES + 1);
  localparam int KW = $clog2(CLEAR_CYCLES + 1);

  heater_state_e state_q, state_d;
  logic [N-1:0]  target_q, target_d;
  logic [N-1:0]  enable_q, enable_d;
  logic [N-1:0]  sticky_q, sticky_d;
  logic [N-1:0]  err_q;
  logic [TW-1:0] timer_q, timer_d;
  logic [15:0]   count_q, count_d;

  logic [N-1:0]  err_event, pick_vec, pick_onehot, up_enable;
  logic          pick_high, pick_valid, step_due, room, up_done;
  logic [CW-1:0] ev_cnt;

`ifdef HEATER_SEQ_AUTOCLR_EN
  heater_state_e ret_q, ret_d;
  logic [N-1:0]  clr_mask_q, clr_mask_d;
  logic [KW-1:0] clr_cnt_q, clr_cnt_d;
  logic          stop_pend_q, stop_pend_d;
`endif

  function automatic logic [CW-1:0] popcount(input logic [N-1:0] v);
    logic [CW-1:0] c;
    c = '0;
    for (int i = 0; i < N; i++) c = c + CW'(v[i]);
    return c;
  endfunction

  // One picker serves both directions: lowest missing target going up, highest enabled going down.
  assign pick_high = (state_q == RAMP_DOWN);
  assign pick_vec  = pick_high ? enable_q : (target_q & ~enable_q);

  heater_bit_pick #(.N(N)) u_pick (
    .vec_i    (pick_vec),
    .high_i   (pick_high),
    .onehot_o (pick_onehot),
    .valid_o  (pick_valid)
  );

  assign err_event = heater_error & ~err_q & enable_q;
  assign ev_cnt    = popcount(err_event);
  assign step_due  = (timer_q == TW'(1));
  assign room      = popcount(enable_q) < CW'(MAX_ON);
  assign up_enable = (pick_valid && room) ? (enable_q | pick_onehot) : enable_q;
  assign up_done   = ((target_q & ~up_enable) == '0) || (popcount(up_enable) >= CW'(MAX_ON));

  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    enable_d = enable_q;
    timer_d  = timer_q;
    sticky_d = (sticky_clr ? '0 : sticky_q) | err_event;
    count_d  = sticky_clr ? 16'(ev_cnt) : sat_add16(count_q, 16'(ev_cnt));
`ifdef HEATER_SEQ_AUTOCLR_EN
    ret_d       = ret_q;
    clr_mask_d  = clr_mask_q;
    clr_cnt_d   = clr_cnt_q;
    stop_pend_d = stop_pend_q;
`endif

    case (state_q)
      IDLE: begin
        if (start) begin
          target_d = target_mask;
          timer_d  = TW'(STEP_CYCLES);
          state_d  = RAMP_UP;
        end
      end

      RAMP_UP: begin
`ifdef HEATER_SEQ_AUTOCLR_EN
        if (|err_event) begin
          state_d     = CLEAR;
          ret_d       = RAMP_UP;
          clr_mask_d  = err_event;
          clr_cnt_d   = KW'(CLEAR_CYCLES);
          stop_pend_d = stop;
        end else
`endif
        if (stop) begin
          state_d = RAMP_DOWN;
          timer_d = TW'(STEP_CYCLES);
        end else if (step_due) begin
          enable_d = up_enable;
          timer_d  = TW'(STEP_CYCLES);
          if (up_done) state_d = RUN;
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end

      RUN: begin
`ifdef HEATER_SEQ_AUTOCLR_EN
        if (|err_event) begin
          state_d     = CLEAR;
          ret_d       = RUN;
          clr_mask_d  = err_event;
          clr_cnt_d   = KW'(CLEAR_CYCLES);
          stop_pend_d = stop;
        end else
`endif
        if (stop) begin
          state_d = RAMP_DOWN;
          timer_d = TW'(STEP_CYCLES);
        end
      end

`ifdef HEATER_SEQ_AUTOCLR_EN
      // The step timer is left untouched here so an interrupted ramp resumes where it paused.
      CLEAR: begin
        stop_pend_d = stop_pend_q | stop;
        if (|err_event) begin
          clr_mask_d = clr_mask_q | err_event;
          clr_cnt_d  = KW'(CLEAR_CYCLES);
        end else if (clr_cnt_q == KW'(1)) begin
          clr_mask_d = '0;
          clr_cnt_d  = '0;
          if (stop_pend_q || stop) begin
            state_d     = RAMP_DOWN;
            timer_d     = TW'(STEP_CYCLES);
            stop_pend_d = 1'b0;
          end else begin
            state_d = ret_q;
          end
        end else begin
          clr_cnt_d = clr_cnt_q - KW'(1);
        end
      end
`endif

      RAMP_DOWN: begin
        if (enable_q == '0) begin
          state_d = IDLE;
          timer_d = '0;
        end else if (step_due) begin
          enable_d = enable_q & ~pick_onehot;
          timer_d  = TW'(STEP_CYCLES);
          if ((enable_q & ~pick_onehot) == '0) begin
            state_d = IDLE;
            timer_d = '0;
          end
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      target_q    <= '0;
      enable_q    <= '0;
      sticky_q    <= '0;
      err_q       <= '0;
      timer_q     <= '0;
      count_q     <= '0;
`ifdef HEATER_SEQ_AUTOCLR_EN
      ret_q       <= IDLE;
      clr_mask_q  <= '0;
      clr_cnt_q   <= '0;
      stop_pend_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      target_q    <= target_d;
      enable_q    <= enable_d;
      sticky_q    <= sticky_d;
      err_q       <= heater_error;
      timer_q     <= timer_d;
      count_q     <= count_d;
`ifdef HEATER_SEQ_AUTOCLR_EN
      ret_q       <= ret_d;
      clr_mask_q  <= clr_mask_d;
      clr_cnt_q   <= clr_cnt_d;
      stop_pend_q <= stop_pend_d;
`endif
    end
  end

`ifdef HEATER_SEQ_AUTOCLR_EN
  assign heater_err_clear = (state_q == CLEAR) ? clr_mask_q : '0;
`else
  assign heater_err_clear = '0;
`endif

  assign heater_enable = enable_q;
  assign error_sticky  = sticky_q;
  assign error_count   = count_q;
  assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_heater_sequencer.sv
// Scoreboard bench for heater_sequencer: expected enable/err_clear transitions are queued with their cycle.
// Builds for either setting of HEATER_SEQ_AUTOCLR_EN.
module tb_heater_sequencer;

  localparam int N   = 16;
  localparam int STP = 10;
  localparam int CLR = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start, stop, sticky_clr;
  logic [N-1:0]  target_mask, heater_error;
  logic [N-1:0]  heater_enable, heater_err_clear, error_sticky;
  logic [15:0]   error_count;
  logic          busy;

  int cyc = 0;
  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    int          cyc;
    logic [15:0] val;
  } expEvt_t;

  expEvt_t     enQ[$];
  expEvt_t     clrQ[$];
  expEvt_t     monEvt;
  logic [15:0] lastEn = '0;
  logic [15:0] lastClr = '0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  heater_sequencer #(
    .N(N), .MAX_ON(8), .STEP_CYCLES(STP), .CLEAR_CYCLES(CLR)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .start            (start),
    .stop             (stop),
    .target_mask      (target_mask),
    .heater_enable    (heater_enable),
    .heater_err_clear (heater_err_clear),
    .heater_error     (heater_error),
    .sticky_clr       (sticky_clr),
    .error_sticky     (error_sticky),
    .error_count      (error_count),
    .busy             (busy)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expected);
    vectors++;
    if (obs !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, want %0h (cycle %0d)", tag, obs, expected, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic pushEn(input int c, input logic [15:0] v);
    expEvt_t e;
    e.cyc = c;
    e.val = v;
    enQ.push_back(e);
  endtask

  task automatic pushClr(input int c, input logic [15:0] v);
    expEvt_t e;
    e.cyc = c;
    e.val = v;
    clrQ.push_back(e);
  endtask

  // An error rising at drive cycle c is cleared for CLR cycles starting on the next edge.
  task automatic expectClear(input int c, input logic [15:0] m);
`ifdef HEATER_SEQ_AUTOCLR_EN
    pushClr(c + 1, m);
    pushClr(c + 1 + CLR, 16'h0000);
`else
    if (m == 16'h0000) pushClr(c, 16'h0000);
`endif
  endtask

  task automatic applyStimulus(input logic s, input logic p, input logic [15:0] mask);
    start       = s;
    stop        = p;
    target_mask = mask;
    tick(1);
    start = 1'b0;
    stop  = 1'b0;
  endtask

  task automatic pulseError(input logic [15:0] m, input logic clr);
    heater_error = m;
    sticky_clr   = clr;
    tick(1);
    heater_error = '0;
    sticky_clr   = 1'b0;
  endtask

  task automatic waitDrain(input string tag, input int budget);
    int n;
    n = 0;
    while ((enQ.size() != 0 || clrQ.size() != 0) && n < budget) begin
      tick(1);
      n++;
    end
    checkOutput({tag, "_en_left"}, enQ.size(), 0);
    checkOutput({tag, "_clr_left"}, clrQ.size(), 0);
    enQ.delete();
    clrQ.delete();
  endtask

  // Every transition of heater_enable / heater_err_clear must match the head of its queue.
  always @(posedge clk) begin
    #1;
    if (!rst_n) begin
      lastEn  = heater_enable;
      lastClr = heater_err_clear;
    end else begin
      if (heater_enable !== lastEn) begin
        if (enQ.size() == 0) begin
          checkOutput("en_unexpected", heater_enable, lastEn);
        end else begin
          monEvt = enQ.pop_front();
          checkOutput("en_val", heater_enable, monEvt.val);
          checkOutput("en_cyc", cyc, monEvt.cyc);
        end
        lastEn = heater_enable;
      end
      if (heater_err_clear !== lastClr) begin
        if (clrQ.size() == 0) begin
          checkOutput("clr_unexpected", heater_err_clear, lastClr);
        end else begin
          monEvt = clrQ.pop_front();
          checkOutput("clr_val", heater_err_clear, monEvt.val);
          checkOutput("clr_cyc", cyc, monEvt.cyc);
        end
        lastClr = heater_err_clear;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int          c;
    int          expCount;
    logic [15:0] expSticky;

    rst_n        = 1'b0;
    start        = 1'b0;
    stop         = 1'b0;
    sticky_clr   = 1'b0;
    target_mask  = '0;
    heater_error = '0;
    expCount     = 0;
    expSticky    = '0;
    tick(2);
    checkOutput("rst_enable", heater_enable, 0);
    checkOutput("rst_errclr", heater_err_clear, 0);
    checkOutput("rst_sticky", error_sticky, 0);
    checkOutput("rst_count", error_count, 0);
    checkOutput("rst_busy", busy, 0);
    rst_n = 1'b1;
    tick(2);

    $display("[TB] ramp-up to current limit");
    c = cyc;
    for (int k = 0; k < 8; k++) pushEn(c + 11 + STP * k, 16'((1 << (k + 1)) - 1));
    applyStimulus(1'b1, 1'b0, 16'hFFFF);
    checkOutput("busy_after_start", busy, 1);
    waitDrain("ramp", 200);
    tick(40);
    checkOutput("ramp_final", heater_enable, 16'h00FF);
    applyStimulus(1'b1, 1'b0, 16'hFF00);
    tick(30);
    checkOutput("start_in_run", heater_enable, 16'h00FF);
    checkOutput("busy_run", busy, 1);

    $display("[TB] single error");
    c = cyc;
`ifdef HEATER_SEQ_AUTOCLR_EN
    expectClear(c, 16'h0008);
    pulseError(16'h0008, 1'b0);
    expSticky = 16'h0008;
`else
    pulseError(16'h0004, 1'b0);
    expSticky = 16'h0004;
`endif
    expCount = 1;
    checkOutput("sticky_single", error_sticky, expSticky);
    checkOutput("count_single", error_count, expCount);
    tick(8);
    waitDrain("single", 20);
    checkOutput("errclr_idle", heater_err_clear, 0);
    checkOutput("busy_after_err", busy, 1);
    checkOutput("en_after_err", heater_enable, 16'h00FF);

    $display("[TB] simultaneous errors");
    c = cyc;
    expectClear(c, 16'h0022);
    pulseError(16'h0022, 1'b0);
    expCount  = expCount + 2;
    expSticky = expSticky | 16'h0022;
    checkOutput("count_dual", error_count, expCount);
    checkOutput("sticky_dual", error_sticky, expSticky);
    tick(8);
    waitDrain("dual", 20);

    pulseError(16'h1000, 1'b0);
    tick(8);
    checkOutput("count_disabled_ch", error_count, expCount);
    checkOutput("sticky_disabled_ch", error_sticky, expSticky);

    $display("[TB] stop and ramp-down");
    c = cyc;
`ifdef HEATER_SEQ_AUTOCLR_EN
    expectClear(c, 16'h0001);
    for (int k = 0; k < 8; k++) pushEn(c + 5 + STP + STP * k, 16'(8'hFF >> (k + 1)));
    pulseError(16'h0001, 1'b0);
    tick(1);
    applyStimulus(1'b0, 1'b1, 16'h0000);
    expCount  = expCount + 1;
    expSticky = expSticky | 16'h0001;
`else
    for (int k = 0; k < 8; k++) pushEn(c + 11 + STP * k, 16'(8'hFF >> (k + 1)));
    applyStimulus(1'b0, 1'b1, 16'h0000);
`endif
    waitDrain("rampdown", 200);
    checkOutput("busy_rampdown_end", busy, 0);
    checkOutput("en_rampdown_end", heater_enable, 0);
    checkOutput("count_rampdown", error_count, expCount);
    checkOutput("sticky_rampdown", error_sticky, expSticky);
    applyStimulus(1'b0, 1'b1, 16'h0000);
    tick(5);
    checkOutput("stop_in_idle", busy, 0);

    $display("[TB] reset mid-ramp");
    c = cyc;
    pushEn(c + 11, 16'h0001);
    pushEn(c + 21, 16'h0003);
    pushEn(c + 31, 16'h0007);
    applyStimulus(1'b1, 1'b0, 16'hFFFF);
    waitDrain("pre_rst", 100);
    checkOutput("en_pre_rst", heater_enable, 16'h0007);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_enable", heater_enable, 0);
    checkOutput("midrst_errclr", heater_err_clear, 0);
    checkOutput("midrst_sticky", error_sticky, 0);
    checkOutput("midrst_count", error_count, 0);
    checkOutput("midrst_busy", busy, 0);
    tick(1);
    rst_n = 1'b1;
    tick(2);
    expCount  = 0;
    expSticky = '0;
    c = cyc;
    for (int k = 0; k < 8; k++) pushEn(c + 11 + STP * k, 16'((1 << (k + 1)) - 1));
    applyStimulus(1'b1, 1'b0, 16'hFFFF);
    waitDrain("reramp", 200);
    checkOutput("reramp_final", heater_enable, 16'h00FF);

    $display("[TB] sticky clear");
    c = cyc;
    expectClear(c, 16'h0004);
    pulseError(16'h0004, 1'b0);
    checkOutput("sticky_pre_clr", error_sticky, 16'h0004);
    checkOutput("count_pre_clr", error_count, 1);
    tick(8);
    waitDrain("preclr", 20);
    pulseError(16'h0000, 1'b1);
    checkOutput("sticky_cleared", error_sticky, 0);
    checkOutput("count_cleared", error_count, 0);
    c = cyc;
    expectClear(c, 16'h0040);
    pulseError(16'h0040, 1'b1);
    checkOutput("sticky_clr_vs_err", error_sticky, 16'h0040);
    checkOutput("count_clr_vs_err", error_count, 1);
    tick(8);
    waitDrain("clrerr", 20);

    $display("[TB] count saturation");
    c = cyc;
`ifdef HEATER_SEQ_AUTOCLR_EN
    pushClr(c + 1, 16'h00FF);
`endif
    for (int i = 0; i < 8190; i++) begin
      heater_error = 16'h00FF;
      tick(1);
      heater_error = '0;
      tick(1);
    end
    checkOutput("count_near_sat", error_count, 16'hFFF1);
    for (int i = 0; i < 10; i++) begin
      heater_error = 16'h00FF;
      tick(1);
      heater_error = '0;
      tick(1);
    end
`ifdef HEATER_SEQ_AUTOCLR_EN
    pushClr(cyc - 2 + 1 + CLR, 16'h0000);
`endif
    tick(8);
    waitDrain("sat", 20);
    checkOutput("count_saturated", error_count, 16'hFFFF);
    checkOutput("sticky_sat", error_sticky, 16'h00FF);
    checkOutput("en_sat", heater_enable, 16'h00FF);
    checkOutput("busy_sat", busy, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
